ex_stage_md: RTL and testbench

Next-generation execute stage with a registered EX/MEM output. It keeps the existing single-cycle ALU path and adds an iterative RV32M multiply/divide engine. While the engine runs, the stage raises ex_stall to hold IF/ID/ID-EX and inserts bubbles into EX/MEM. It supports an EX flush and the global DCACHE_stall freeze.

---
 rtl/ex_stage_md_if.sv | 50 +++++
 rtl/ex_stage_md.sv | 253 +++++++++++++++++++++++++
 tb/tb_ex_stage_md.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_md_if.sv
// EX-stage bundle: instruction/operand inputs from ID-EX, EX/MEM register outputs and the stall/flush controls.
interface ex_stage_md_if #(
  parameter int BIT_W = 32,
  parameter int RD_W  = 5
);
  logic [BIT_W-1:0] PC_in;
  logic [BIT_W-1:0] rs1_dat_in;
  logic [BIT_W-1:0] rs2_dat_in;
  logic [BIT_W-1:0] imm;
  logic             alusrc_in;
  logic [3:0]       aluctrl_in;
  logic             jal_in;
  logic             jalr_in;
  logic             md_valid_in;
  logic [2:0]       md_op_in;
  logic [RD_W-1:0]  rd_in;
  logic             memrd_in;
  logic             memwr_in;
  logic             mem2reg_in;
  logic             regwr_in;
  logic             DCACHE_stall;
  logic             flush_in;

  logic [BIT_W-1:0] alu_result;
  logic [BIT_W-1:0] mem_wdata;
  logic [RD_W-1:0]  rd_out;
  logic [BIT_W-1:0] PC_plus_4;
  logic             memrd_out;
  logic             memwr_out;
  logic             mem2reg_out;
  logic             regwr_out;
  logic             jump_out;
  logic             ex_stall;

  modport master (
    output PC_in, rs1_dat_in, rs2_dat_in, imm, alusrc_in, aluctrl_in, jal_in, jalr_in,
           md_valid_in, md_op_in, rd_in, memrd_in, memwr_in, mem2reg_in, regwr_in,
           DCACHE_stall, flush_in,
    input  alu_result, mem_wdata, rd_out, PC_plus_4, memrd_out, memwr_out, mem2reg_out,
           regwr_out, jump_out, ex_stall
  );

  modport slave (
    input  PC_in, rs1_dat_in, rs2_dat_in, imm, alusrc_in, aluctrl_in, jal_in, jalr_in,
           md_valid_in, md_op_in, rd_in, memrd_in, memwr_in, mem2reg_in, regwr_in,
           DCACHE_stall, flush_in,
    output alu_result, mem_wdata, rd_out, PC_plus_4, memrd_out, memwr_out, mem2reg_out,
           regwr_out, jump_out, ex_stall
  );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU plus an iterative RV32M multiply/divide engine, registered EX/MEM output.
// state | meaning
// IDLE  | ALU path; M op accepted here (divide special cases go straight to DONE)
// BUSY  | one shift-add / restoring shift-subtract step per cycle, BIT_W steps
// DONE  | M result final; captured into EX/MEM this cycle
module ex_stage_md #(
  parameter int BIT_W = 32,
  parameter int RD_W  = 5
) (
  input logic          clk,
  input logic          rst_n,
  ex_stage_md_if.slave ex
);
  localparam int CNT_W = $clog2(BIT_W);
  localparam logic [BIT_W-1:0] MIN_NEG = {1'b1, {(BIT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [BIT_W-1:0] opd_q, opd_d;
  logic [BIT_W-1:0] acc_hi_q, acc_hi_d;
  logic [BIT_W-1:0] acc_lo_q, acc_lo_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [RD_W-1:0]  rd_md_q, rd_md_d;

  logic [BIT_W-1:0] alu_result_q, alu_result_d;
  logic [BIT_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [RD_W-1:0]  rd_out_q, rd_out_d;
  logic [BIT_W-1:0] pc_plus_4_q, pc_plus_4_d;
  logic             memrd_q, memrd_d;
  logic             memwr_q, memwr_d;
  logic             mem2reg_q, mem2reg_d;
  logic             regwr_q, regwr_d;
  logic             jump_q, jump_d;

  logic             stall;
  logic [BIT_W-1:0] op_a, op_b, alu_out;
  logic [CNT_W-1:0] shamt;
  logic             a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [BIT_W-1:0] a_mag, b_mag;
  logic [BIT_W:0]   mul_sum, div_trial;
  logic [BIT_W-1:0] step_hi, step_lo;
  logic [2*BIT_W-1:0] prod_s;
  logic [BIT_W-1:0] md_res;

  assign stall = !ex.flush_in &&
                 (((state_q == S_IDLE) && ex.md_valid_in) || (state_q == S_BUSY));

  always_comb begin
    op_a  = ex.jal_in ? ex.PC_in : ex.rs1_dat_in;
    op_b  = ex.alusrc_in ? ex.imm : ex.rs2_dat_in;
    shamt = op_b[CNT_W-1:0];
    case (ex.aluctrl_in)
      4'b0000: alu_out = op_a + op_b;
      4'b1000: alu_out = op_a - op_b;
      4'b0001: alu_out = op_a << shamt;
      4'b0010: alu_out = {{(BIT_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0011: alu_out = {{(BIT_W-1){1'b0}}, (op_a < op_b)};
      4'b0100: alu_out = op_a ^ op_b;
      4'b0101: alu_out = op_a >> shamt;
      4'b1101: alu_out = BIT_W'($signed(op_a) >>> shamt);
      4'b0110: alu_out = op_a | op_b;
      4'b0111: alu_out = op_a & op_b;
      default: alu_out = op_a + op_b;
    endcase
  end

  // Unsigned variants: MULHU/DIVU/REMU fully unsigned, MULHSU only rs2 unsigned.
  always_comb begin
    a_sgn    = (ex.md_op_in != 3'd3) && (ex.md_op_in != 3'd5) && (ex.md_op_in != 3'd7);
    b_sgn    = a_sgn && (ex.md_op_in != 3'd2);
    a_neg    = a_sgn && ex.rs1_dat_in[BIT_W-1];
    b_neg    = b_sgn && ex.rs2_dat_in[BIT_W-1];
    a_mag    = a_neg ? -ex.rs1_dat_in : ex.rs1_dat_in;
    b_mag    = b_neg ? -ex.rs2_dat_in : ex.rs2_dat_in;
    is_div   = ex.md_op_in[2];
    div_zero = is_div && (ex.rs2_dat_in == '0);
    div_ovf  = is_div && a_sgn && (ex.rs1_dat_in == MIN_NEG) && (&ex.rs2_dat_in);
  end

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
    div_trial = {acc_hi_q, acc_lo_q[BIT_W-1]} - {1'b0, opd_q};
    if (op_q[2]) begin
      if (!div_trial[BIT_W]) begin
        step_hi = div_trial[BIT_W-1:0];
        step_lo = {acc_lo_q[BIT_W-2:0], 1'b1};
      end else begin
        step_hi = {acc_hi_q[BIT_W-2:0], acc_lo_q[BIT_W-1]};
        step_lo = {acc_lo_q[BIT_W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[BIT_W:1];
      step_lo = {mul_sum[0], acc_lo_q[BIT_W-1:1]};
    end
  end

  // Engine works on magnitudes; the sign is restored here once the result is final.
  always_comb begin
    prod_s = res_neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    case (op_q)
      3'd0:          md_res = prod_s[BIT_W-1:0];
      3'd1, 3'd2, 3'd3: md_res = prod_s[2*BIT_W-1:BIT_W];
      3'd4, 3'd5:    md_res = res_neg_q ? -acc_lo_q : acc_lo_q;
      default:       md_res = rem_neg_q ? -acc_hi_q : acc_hi_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opd_d     = opd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    rd_md_d   = rd_md_q;
    if (!ex.DCACHE_stall) begin
      if (ex.flush_in) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ex.md_valid_in) begin
              op_d    = ex.md_op_in;
              rd_md_d = ex.rd_in;
              cnt_d   = '0;
              if (div_zero || div_ovf) begin
                state_d   = S_DONE;
                acc_lo_d  = div_zero ? '1 : ex.rs1_dat_in;
                acc_hi_d  = div_zero ? ex.rs1_dat_in : '0;
                res_neg_d = 1'b0;
                rem_neg_d = 1'b0;
              end else begin
                state_d   = S_BUSY;
                acc_hi_d  = '0;
                acc_lo_d  = is_div ? a_mag : b_mag;
                opd_d     = is_div ? b_mag : a_mag;
                res_neg_d = a_neg ^ b_neg;
                rem_neg_d = a_neg;
              end
            end
          end
          S_BUSY: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIT_W-1)) state_d = S_DONE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    alu_result_d = alu_result_q;
    mem_wdata_d  = mem_wdata_q;
    rd_out_d     = rd_out_q;
    pc_plus_4_d  = pc_plus_4_q;
    memrd_d      = memrd_q;
    memwr_d      = memwr_q;
    mem2reg_d    = mem2reg_q;
    regwr_d      = regwr_q;
    jump_d       = jump_q;
    if (!ex.DCACHE_stall) begin
      alu_result_d = '0;
      mem_wdata_d  = '0;
      rd_out_d     = '0;
      pc_plus_4_d  = '0;
      memrd_d      = 1'b0;
      memwr_d      = 1'b0;
      mem2reg_d    = 1'b0;
      regwr_d      = 1'b0;
      jump_d       = 1'b0;
      if (!ex.flush_in && !stall) begin
        pc_plus_4_d = ex.PC_in + BIT_W'(4);
        mem_wdata_d = ex.rs2_dat_in;
        if (state_q == S_DONE) begin
          alu_result_d = md_res;
          rd_out_d     = rd_md_q;
          regwr_d      = 1'b1;
        end else begin
          alu_result_d = alu_out;
          rd_out_d     = ex.rd_in;
          memrd_d      = ex.memrd_in;
          memwr_d      = ex.memwr_in;
          mem2reg_d    = ex.mem2reg_in;
          regwr_d      = ex.regwr_in;
          jump_d       = ex.jal_in | ex.jalr_in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      opd_q        <= '0;
      acc_hi_q     <= '0;
      acc_lo_q     <= '0;
      res_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      rd_md_q      <= '0;
      alu_result_q <= '0;
      mem_wdata_q  <= '0;
      rd_out_q     <= '0;
      pc_plus_4_q  <= '0;
      memrd_q      <= 1'b0;
      memwr_q      <= 1'b0;
      mem2reg_q    <= 1'b0;
      regwr_q      <= 1'b0;
      jump_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      opd_q        <= opd_d;
      acc_hi_q     <= acc_hi_d;
      acc_lo_q     <= acc_lo_d;
      res_neg_q    <= res_neg_d;
      rem_neg_q    <= rem_neg_d;
      rd_md_q      <= rd_md_d;
      alu_result_q <= alu_result_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_out_q     <= rd_out_d;
      pc_plus_4_q  <= pc_plus_4_d;
      memrd_q      <= memrd_d;
      memwr_q      <= memwr_d;
      mem2reg_q    <= mem2reg_d;
      regwr_q      <= regwr_d;
      jump_q       <= jump_d;
    end
  end

  assign ex.alu_result  = alu_result_q;
  assign ex.mem_wdata   = mem_wdata_q;
  assign ex.rd_out      = rd_out_q;
  assign ex.PC_plus_4   = pc_plus_4_q;
  assign ex.memrd_out   = memrd_q;
  assign ex.memwr_out   = memwr_q;
  assign ex.mem2reg_out = mem2reg_q;
  assign ex.regwr_out   = regwr_q;
  assign ex.jump_out    = jump_q;
  assign ex.ex_stall    = stall;
endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: queued expectations from a 64-bit arithmetic reference, popped by an output monitor.
module tb_ex_stage_md;
  localparam int BIT_W = 32;
  localparam int RD_W  = 5;
  localparam logic [3:0] ALU_CODES [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                           4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic        alusrc;
    logic [3:0]  alu;
    logic        jal, jalr, md;
    logic [2:0]  mop;
    logic [4:0]  rd;
    logic        memrd, memwr, mem2reg, regwr;
  } instr_t;

  typedef struct {
    logic [31:0] res, pc4, wdata;
    logic [4:0]  rd;
    logic [4:0]  ctl;
    bit          full;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   drv_valid = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ex_stage_md_if #(.BIT_W(BIT_W), .RD_W(RD_W)) bus ();
  ex_stage_md #(.BIT_W(BIT_W), .RD_W(RD_W)) dut (.clk(clk), .rst_n(rst_n), .ex(bus));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b[4:0];
    case (c)
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return 32'($signed(a) >>> sh);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin u = 64'(ua * ub); return u[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int stall_base(input instr_t i);
    if (!i.md) return 0;
    if (i.mop[2] && (i.rs2 == 0 ||
        (!i.mop[0] && i.rs1 == 32'h8000_0000 && i.rs2 == 32'hFFFF_FFFF))) return 1;
    return BIT_W + 1;
  endfunction

  function automatic exp_t mk_exp(input instr_t i);
    exp_t e;
    e.rd = i.rd;
    if (i.md) begin
      e.res = ref_md(i.mop, i.rs1, i.rs2);
      e.ctl = 5'b10000;
      e.pc4 = '0;
      e.wdata = '0;
      e.full = 1'b0;
    end else begin
      e.res = ref_alu(i.alu, i.jal ? i.pc : i.rs1, i.alusrc ? i.imm : i.rs2);
      e.ctl = {i.regwr, i.memrd, i.memwr, i.mem2reg, i.jal | i.jalr};
      e.pc4 = i.pc + 32'd4;
      e.wdata = i.rs2;
      e.full = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'(0 - $urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  function automatic instr_t mk_instr(input bit md, input logic [2:0] mop, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] rd);
    instr_t i;
    i = '{pc: 32'h0, rs1: a, rs2: b, imm: 32'h0, alusrc: 1'b0, alu: 4'b0000, jal: 1'b0,
          jalr: 1'b0, md: md, mop: mop, rd: rd, memrd: 1'b0, memwr: 1'b0, mem2reg: 1'b0,
          regwr: !md};
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    i = mk_instr($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                 5'($urandom_range(0, 31)));
    i.pc     = $urandom() & 32'hFFFF_FFFC;
    i.imm    = rnd_val();
    i.alusrc = $urandom_range(0, 1) == 1;
    i.alu    = ALU_CODES[$urandom_range(0, 9)];
    if (!i.md) begin
      i.jal     = $urandom_range(0, 7) == 0;
      i.jalr    = $urandom_range(0, 7) == 0;
      i.memrd   = $urandom_range(0, 1) == 1;
      i.memwr   = $urandom_range(0, 1) == 1;
      i.mem2reg = $urandom_range(0, 1) == 1;
      i.regwr   = $urandom_range(0, 1) == 1;
    end
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus.PC_in       = i.pc;
    bus.rs1_dat_in  = i.rs1;
    bus.rs2_dat_in  = i.rs2;
    bus.imm         = i.imm;
    bus.alusrc_in   = i.alusrc;
    bus.aluctrl_in  = i.alu;
    bus.jal_in      = i.jal;
    bus.jalr_in     = i.jalr;
    bus.md_valid_in = i.md;
    bus.md_op_in    = i.mop;
    bus.rd_in       = i.rd;
    bus.memrd_in    = i.memrd;
    bus.memwr_in    = i.memwr;
    bus.mem2reg_in  = i.mem2reg;
    bus.regwr_in    = i.regwr;
  endtask

  // Called at a falling edge; returns at the falling edge after the instruction leaves EX.
  task automatic issue(input instr_t i, input int fa, input int da, input int dl, output int ns);
    int  k;
    bit  fire;
    k  = 0;
    ns = 0;
    drive(i);
    drv_valid = 1'b1;
    if (fa < 0) sb_q.push_back(mk_exp(i));
    forever begin
      bus.DCACHE_stall = (k >= da) && (k < da + dl);
      bus.flush_in     = (k == fa) && !bus.DCACHE_stall;
      #1;
      if (bus.ex_stall) ns++;
      fire = !bus.DCACHE_stall && (bus.flush_in || !bus.ex_stall);
      @(posedge clk);
      @(negedge clk);
      k++;
      if (fire) break;
      if (k > 200) begin
        total++;
        bad++;
        $display("FAIL issue_timeout: got no capture after %0d cycles, expected one", k);
        break;
      end
    end
    bus.DCACHE_stall = 1'b0;
    bus.flush_in     = 1'b0;
  endtask

  task automatic run(input instr_t i, input int fa, input int da, input int dl);
    int ns, exp_ns;
    issue(i, fa, da, dl, ns);
    if (fa < 0) begin
      exp_ns = stall_base(i);
      if (exp_ns > 0) exp_ns += dl;
      chk("stall_cycles", 32'(ns), 32'(exp_ns));
    end else begin
      bus.md_valid_in = 1'b0;
      drv_valid = 1'b0;
      #1;
      chk("flush_ex_stall", 32'(bus.ex_stall), 32'd0);
      chk("flush_regwr", 32'(bus.regwr_out), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_result"}, bus.alu_result, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_pc_plus_4"}, bus.PC_plus_4, 32'd0);
    chk({tag, "_rd_out"}, 32'(bus.rd_out), 32'd0);
    chk({tag, "_ctl"}, 32'({bus.regwr_out, bus.memrd_out, bus.memwr_out, bus.mem2reg_out,
                            bus.jump_out}), 32'd0);
    chk({tag, "_ex_stall"}, 32'(bus.ex_stall), 32'd0);
  endtask

  // Monitor: decides at each falling edge what the next rising edge must load, then checks it.
  initial begin
    exp_t        e;
    bit          pend_fire, pend_bubble, pend_hold;
    logic [31:0] snap_res;
    logic [4:0]  snap_ctl, ctl_now;
    pend_fire = 1'b0;
    pend_bubble = 1'b0;
    pend_hold = 1'b0;
    forever begin
      @(negedge clk);
      ctl_now = {bus.regwr_out, bus.memrd_out, bus.memwr_out, bus.mem2reg_out, bus.jump_out};
      if (pend_fire) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_capture: got result %h with no queued expectation",
                   bus.alu_result);
        end else begin
          e = sb_q.pop_front();
          chk("result", bus.alu_result, e.res);
          chk("rd_out", 32'(bus.rd_out), 32'(e.rd));
          chk("ctl", 32'(ctl_now), 32'(e.ctl));
          if (e.full) begin
            chk("pc_plus_4", bus.PC_plus_4, e.pc4);
            chk("mem_wdata", bus.mem_wdata, e.wdata);
          end
        end
      end
      if (pend_bubble) chk("bubble_ctl", 32'(ctl_now), 32'd0);
      if (pend_hold) begin
        chk("hold_result", bus.alu_result, snap_res);
        chk("hold_ctl", 32'(ctl_now), 32'(snap_ctl));
      end
      snap_res = bus.alu_result;
      snap_ctl = ctl_now;
      #1;
      pend_fire   = rst_n && drv_valid && !bus.DCACHE_stall && !bus.flush_in && !bus.ex_stall;
      pend_bubble = rst_n && !bus.DCACHE_stall && (bus.flush_in || bus.ex_stall);
      pend_hold   = rst_n && bus.DCACHE_stall;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t i;
    int     base, fa, da, dl, r;
    i = mk_instr(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    i.regwr = 1'b0;
    drive(i);
    bus.DCACHE_stall = 1'b0;
    bus.flush_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    i = mk_instr(1'b0, 3'd0, 32'd5, 32'd0, 5'd1);
    i.imm = 32'd3; i.alusrc = 1'b1; i.pc = 32'h100;
    run(i, -1, 0, 0);
    run(mk_instr(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd2), -1, 0, 0);
    run(mk_instr(1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3), -1, 0, 0);
    run(mk_instr(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4), -1, 0, 0);
    run(mk_instr(1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5), -1, 0, 0);
    run(mk_instr(1'b1, 3'd7, 32'd5, 32'd0, 5'd6), -1, 0, 0);
    run(mk_instr(1'b1, 3'd5, 32'd5, 32'd0, 5'd7), -1, 0, 0);
    run(mk_instr(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8), -1, 0, 0);
    run(mk_instr(1'b1, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9), -1, 0, 0);
    run(mk_instr(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd10), -1, 10, 4);
    run(mk_instr(1'b1, 3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11), 12, 0, 0);
    run(mk_instr(1'b1, 3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 5'd12), -1, 0, 0);

    for (int n = 0; n < 120; n++) begin
      i = rnd_instr();
      base = stall_base(i);
      fa = -1;
      da = 0;
      dl = 0;
      r = $urandom_range(0, 9);
      if (r == 0) fa = $urandom_range(0, base);
      else if (r <= 2) begin
        dl = $urandom_range(1, 4);
        da = (base > 0) ? $urandom_range(0, base - 1) : 0;
      end
      run(i, fa, da, dl);
    end

    drv_valid = 1'b0;
    drive(mk_instr(1'b1, 3'd0, 32'd9, 32'd9, 5'd13));
    repeat (10) @(negedge clk);
    bus.md_valid_in = 1'b0;
    rst_n = 1'b0;
    #1 chk_all_zero("reset_busy");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(mk_instr(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd14), -1, 0, 0);

    drv_valid = 1'b0;
    bus.md_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
